// File: rtl/wbm_cmd_master.sv
// wbm_cmd_master: Wishbone classic master running one bus cycle per valid/ready command.
// Define WBM_TIMEOUT_EN to compile in the abort of bus cycles that never see ack/err.
module wbm_cmd_master #(
  parameter int BUS_DATA_WIDTH = 32,
  parameter int BUS_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int BYTE_ENABLES = BUS_DATA_WIDTH / 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [BUS_ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [BYTE_ENABLES-1:0]   cmd_sel_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [BUS_DATA_WIDTH-1:0] rsp_dat_o,
  output logic [1:0]                rsp_status_o,
  output logic                      wbm_cyc_o,
  output logic                      wbm_stb_o,
  output logic                      wbm_we_o,
  output logic [BYTE_ENABLES-1:0]   wbm_sel_o,
  output logic [BUS_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [BUS_DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [BUS_DATA_WIDTH-1:0] wbm_dat_i,
  input  logic                      wbm_ack_i,
  input  logic                      wbm_err_i,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  state_t state, state_next;
  logic   cmd_fire;
  logic   rsp_fire;
  logic   bus_end;
  logic   tmo_hit;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // a response, once valid, holds its payload until that transfer.
  assign cmd_ready_o = wb_rst_i && (state == IDLE) && !wbm_ack_i && !wbm_err_i;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = (state == RESP);
  assign rsp_fire    = rsp_valid_o && rsp_ready_i;
  assign bus_end     = (state == BUS) && (wbm_ack_i || wbm_err_i || tmo_hit);
  assign dbg_state   = state;

`ifdef WBM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // tmo_cnt holds the number of BUS cycles already completed before the current edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (cmd_fire) begin
      tmo_cnt <= '0;
    end else if ((state == BUS) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (state == BUS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = BUS;
      BUS:     if (bus_end)  state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus signals are loaded once on accept and stay put for the whole cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_we_o     <= 1'b0;
      wbm_sel_o    <= '0;
      wbm_adr_o    <= '0;
      wbm_dat_o    <= '0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_OK;
    end else if (cmd_fire) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= cmd_we_i;
      wbm_sel_o <= cmd_sel_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_dat_i;
    end else if (bus_end) begin
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      rsp_status_o <= wbm_err_i ? ST_ERR : (wbm_ack_i ? ST_OK : ST_TMO);
      rsp_dat_o    <= (wbm_ack_i && !wbm_err_i && !wbm_we_o) ? wbm_dat_i : '0;
    end
  end

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Bench for wbm_cmd_master: registered zero-wait Wishbone memory slave, scoreboarded responses.
// Build with WBM_TIMEOUT_EN defined to add the timeout scenario.
module tb_wbm_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [7:0]  wbm_adr;
  logic [31:0] wbm_dat_o, wbm_dat_i;
  logic        wbm_ack, wbm_err;
  logic [1:0]  dbg_state;

  logic        slv_ack, slv_err;
  logic [31:0] slv_dat;
  logic [31:0] mem [0:255];
  logic        hang = 1'b0;
  logic        err_en = 1'b0;
  logic [7:0]  err_adr = 8'h20;
  logic        stray_ack = 1'b0;
  logic        stray_err = 1'b0;
  logic        rand_rdy = 1'b0;

  logic [31:0] model_mem [0:255];
  logic [33:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  assign wbm_ack   = slv_ack | stray_ack;
  assign wbm_err   = slv_err | stray_err;
  assign wbm_dat_i = slv_dat;

  wbm_cmd_master #(
    .BUS_DATA_WIDTH(32),
    .BUS_ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_status_o(rsp_status),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack),
    .wbm_err_i   (wbm_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Registered slave: ack (or err+ack) one edge after seeing stb; junk read data otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_ack <= 1'b0;
      slv_err <= 1'b0;
      slv_dat <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      slv_ack <= 1'b0;
      slv_err <= 1'b0;
      slv_dat <= $urandom;
      if (wbm_cyc && wbm_stb && !slv_ack && !slv_err && !hang) begin
        slv_ack <= 1'b1;
        if (err_en && wbm_adr == err_adr) begin
          slv_err <= 1'b1;
          slv_dat <= 32'hBAD0_BAD0;
        end else if (wbm_we) begin
          for (int b = 0; b < 4; b++)
            if (wbm_sel[b]) mem[wbm_adr][8*b +: 8] <= wbm_dat_o[8*b +: 8];
        end else begin
          slv_dat <= mem[wbm_adr];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare each accepted response against the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_status", 64'(rsp_status), 64'(e[33:32]));
        check("rsp_dat", 64'(rsp_dat), 64'(e[31:0]));
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
  endtask

  // driver tasks
  task automatic issue_cmd(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    logic [1:0]  est;
    logic [31:0] edat;
    int          n;
    est  = 2'b00;
    edat = '0;
    if (hang) est = 2'b10;
    else if (err_en && adr == err_adr) est = 2'b01;
    else if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) model_mem[adr][8*b +: 8] = dat[8*b +: 8];
    end else edat = model_mem[adr];
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    exp_q.push_back({est, edat});
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bus_drive", 64'({wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o}),
          64'({2'b11, we, sel, adr, dat}));
  endtask

  task automatic wait_rsp(input int exp_lat);
    int k;
    k = 0;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rsp_latency", 64'(k), 64'(exp_lat));
    check("bus_released", 64'({wbm_cyc, wbm_stb}), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_cmd(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    issue_cmd(we, adr, dat, sel);
    wait_rsp(2);
    drain();
  endtask

  initial begin
    logic [34:0] snap;
    clear_model();
    #12;
    check("reset_ctrl", 64'({cmd_ready, rsp_valid, rsp_status, wbm_cyc, wbm_stb, wbm_we, dbg_state}),
          64'(0));
    check("reset_data", 64'({wbm_sel, wbm_adr, wbm_dat_o, rsp_dat[19:0]}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // basic write then read back
    do_cmd(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    do_cmd(1'b0, 8'h04, 32'h0, 4'hF);

    // partial byte-enable write over existing data
    do_cmd(1'b1, 8'h05, 32'hAAAAAAAA, 4'hF);
    do_cmd(1'b1, 8'h05, 32'h11223344, 4'h3);
    do_cmd(1'b0, 8'h05, 32'h0, 4'hF);

    // slave error on read and write
    err_en = 1'b1;
    do_cmd(1'b0, 8'h20, 32'h0, 4'hF);
    do_cmd(1'b1, 8'h20, 32'h55555555, 4'hF);
    err_en = 1'b0;
    do_cmd(1'b0, 8'h20, 32'h0, 4'hF);

    // response stall with stray ack/err while waiting
    rsp_ready = 1'b0;
    issue_cmd(1'b0, 8'h04, 32'h0, 4'hF);
    wait_rsp(2);
    snap = {rsp_valid, rsp_status, rsp_dat};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      stray_ack = (i == 1);
      stray_err = (i == 2);
      @(negedge clk);
      check("stall_hold", 64'({rsp_valid, rsp_status, rsp_dat}), 64'(snap));
      check("stall_ctrl", 64'({cmd_ready, wbm_cyc, wbm_stb}), 64'(0));
    end
    @(posedge clk); #1;
    stray_ack = 1'b0;
    stray_err = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // lingering ack in IDLE must hold off a new command
    @(posedge clk); #1;
    stray_ack = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 8'h07;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ack_gate", 64'({cmd_ready, wbm_cyc}), 64'(0));
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    stray_ack = 1'b0;
    do_cmd(1'b0, 8'h05, 32'h0, 4'hF);

    // asynchronous reset in the middle of a bus cycle
    hang = 1'b1;
    issue_cmd(1'b1, 8'h10, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({wbm_cyc, wbm_stb, rsp_valid, cmd_ready}), 64'(0));
    exp_q.delete();
    clear_model();
    @(posedge clk); #1;
    hang  = 1'b0;
    rst_n = 1'b1;
    do_cmd(1'b1, 8'h10, 32'h0BADC0DE, 4'hF);
    do_cmd(1'b0, 8'h10, 32'h0, 4'hF);

`ifdef WBM_TIMEOUT_EN
    // slave never answers: abort after 8 bus cycles
    hang = 1'b1;
    issue_cmd(1'b0, 8'h30, 32'h0, 4'hF);
    wait_rsp(8);
    drain();
    hang = 1'b0;
`endif

    // random traffic with random response back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      we  = 1'($urandom_range(0, 1));
      adr = 8'h40 + 8'($urandom_range(0, 7));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      do_cmd(we, adr, dat, sel);
    end
    rand_rdy = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_cmd(1'b0, 8'h04, 32'h0, 4'hF);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
